// File: rtl/lcd_msg_sequencer.sv
// Turns a 2-line character frame buffer into a paced stream of LCD executor commands.
// Optional build macro LCD_MSG_HOLD_EN adds a 2 s hold command at the end of each frame.
module lcd_msg_sequencer #(
  parameter int         COLS       = 16,
  parameter logic [7:0] LINE2_ADDR = 8'h40,
  parameter logic [7:0] FILL_CHAR  = 8'h20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_DATA,
  input  logic       EXE_RDY,
  output logic [3:0] EXE_OP,
  output logic [7:0] EXE_DATA,
  output logic       EXE_ENB,
  output logic       BUSY,
  output logic       DONE
);

  localparam int         DEPTH    = 2 * COLS;
  localparam logic [5:0] DEPTH_W  = 6'(DEPTH);
  localparam logic [4:0] LAST_IDX = 5'(COLS - 1);
  localparam logic [4:0] L2_BASE  = 5'(COLS);

  localparam logic [3:0] OP_CLR  = 4'd0;
  localparam logic [3:0] OP_CHAR = 4'd1;
  localparam logic [3:0] OP_ADDR = 4'd3;
  localparam logic [3:0] OP_HOLD = 4'd4;
  localparam logic [3:0] OP_NOP  = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_ADDR1, S_CHR1, S_ADDR2, S_CHR2, S_FIN
`ifdef LCD_MSG_HOLD_EN
    , S_HOLD
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic       pending, pend_nxt;
  logic [3:0] op_nxt;
  logic [7:0] data_nxt;
  logic       busy_nxt, done_nxt;
  logic       launch, finish;

  logic [7:0] mem [DEPTH];

  // Frame buffer: host writes land every cycle, out-of-range indices dropped
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= FILL_CHAR;
    end else if (WR_EN && ({1'b0, WR_ADDR} < DEPTH_W)) begin
      mem[WR_ADDR] <= WR_DATA;
    end
  end

  // Next-command selection: outputs always carry the command the executor will accept next,
  // so each character is fetched on the edge that accepts its predecessor.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    op_nxt    = EXE_OP;
    data_nxt  = EXE_DATA;
    busy_nxt  = BUSY;
    done_nxt  = 1'b0;
    pend_nxt  = pending | START;
    launch    = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: launch = START | pending;
      S_FIN: begin
        launch = START | pending;
        if (!launch) state_nxt = S_IDLE;
      end
      S_CLR: if (EXE_RDY) begin
        state_nxt = S_ADDR1;
        op_nxt    = OP_ADDR;
        data_nxt  = 8'h00;
      end
      S_ADDR1: if (EXE_RDY) begin
        state_nxt = S_CHR1;
        op_nxt    = OP_CHAR;
        data_nxt  = mem[5'd0];
        idx_nxt   = 5'd0;
      end
      S_CHR1: if (EXE_RDY) begin
        if (idx == LAST_IDX) begin
          state_nxt = S_ADDR2;
          op_nxt    = OP_ADDR;
          data_nxt  = LINE2_ADDR;
          idx_nxt   = 5'd0;
        end else begin
          idx_nxt  = idx + 5'd1;
          data_nxt = mem[idx + 5'd1];
        end
      end
      S_ADDR2: if (EXE_RDY) begin
        state_nxt = S_CHR2;
        op_nxt    = OP_CHAR;
        data_nxt  = mem[L2_BASE];
      end
      S_CHR2: if (EXE_RDY) begin
        if (idx == LAST_IDX) begin
`ifdef LCD_MSG_HOLD_EN
          state_nxt = S_HOLD;
          op_nxt    = OP_HOLD;
          data_nxt  = 8'h00;
          idx_nxt   = 5'd0;
`else
          finish = 1'b1;
`endif
        end else begin
          idx_nxt  = idx + 5'd1;
          data_nxt = mem[L2_BASE + idx + 5'd1];
        end
      end
`ifdef LCD_MSG_HOLD_EN
      S_HOLD: if (EXE_RDY) finish = 1'b1;
`endif
      default: state_nxt = S_IDLE;
    endcase
    if (finish) begin
      state_nxt = S_FIN;
      op_nxt    = OP_NOP;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      idx_nxt   = 5'd0;
    end
    if (launch) begin
      state_nxt = S_CLR;
      op_nxt    = OP_CLR;
      data_nxt  = 8'h00;
      busy_nxt  = 1'b1;
      pend_nxt  = 1'b0;
      idx_nxt   = 5'd0;
    end
  end

  // Control and command output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      idx      <= 5'd0;
      pending  <= 1'b0;
      EXE_OP   <= OP_NOP;
      EXE_DATA <= 8'h00;
      EXE_ENB  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      pending  <= pend_nxt;
      EXE_OP   <= op_nxt;
      EXE_DATA <= data_nxt;
      EXE_ENB  <= 1'b1;
      BUSY     <= busy_nxt;
      DONE     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Directed and randomized bench for lcd_msg_sequencer against a position-based frame model.
module tb_lcd_msg_sequencer;
  localparam int COLS = 16;
`ifdef LCD_MSG_HOLD_EN
  localparam int FLEN = 2 * COLS + 4;
`else
  localparam int FLEN = 2 * COLS + 3;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1, START = 1'b0, WR_EN = 1'b0, EXE_RDY = 1'b0;
  logic [4:0] WR_ADDR = 5'd0;
  logic [7:0] WR_DATA = 8'd0;
  logic [3:0] EXE_OP;
  logic [7:0] EXE_DATA;
  logic       EXE_ENB, BUSY, DONE;

  always #5 CLK = ~CLK;

  lcd_msg_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA), .EXE_RDY(EXE_RDY), .EXE_OP(EXE_OP), .EXE_DATA(EXE_DATA),
    .EXE_ENB(EXE_ENB), .BUSY(BUSY), .DONE(DONE)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: frame position of the pending command plus a shadow buffer
  logic [7:0]  mbuf [2*COLS];
  bit          m_act, m_fin, m_pend;
  int          m_pos;
  logic [3:0]  e_op;
  logic [7:0]  e_data;
  logic        e_enb, e_busy, e_done;
  logic [11:0] acc_log[$];
  logic [11:0] exp_q[$];
  int          done_cnt;

  function automatic logic [11:0] cmd_at(int p);
    if (p == 0) return 12'h000;
    if (p == 1) return 12'h300;
    if (p < COLS + 2) return {4'd1, mbuf[5'(p - 2)]};
    if (p == COLS + 2) return 12'h340;
    if (p < 2 * COLS + 3) return {4'd1, mbuf[5'(p - 3)]};
    return 12'h400;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [11:0] c;
    if (RST) begin
      for (int i = 0; i < 2 * COLS; i++) mbuf[i] = 8'h20;
      m_act = 0; m_fin = 0; m_pend = 0; m_pos = 0;
      e_op = 4'hF; e_data = 8'h00; e_enb = 0; e_busy = 0; e_done = 0;
      return;
    end
    e_enb  = 1;
    e_done = 0;
    if (m_fin || !m_act) begin
      if (START || m_pend) begin
        m_act = 1; m_pos = 0; m_pend = 0;
        e_op = 4'h0; e_data = 8'h00; e_busy = 1;
      end
      m_fin = 0;
    end else begin
      if (START) m_pend = 1;
      if (EXE_RDY) begin
        m_pos++;
        if (m_pos == FLEN) begin
          m_act = 0; m_fin = 1;
          e_op = 4'hF; e_busy = 0; e_done = 1;
        end else begin
          c = cmd_at(m_pos);
          e_op = c[11:8];
          e_data = c[7:0];
        end
      end
    end
    if (WR_EN && int'(WR_ADDR) < 2 * COLS) mbuf[WR_ADDR] = WR_DATA;
  endtask

  task automatic tick(input bit rst, input bit rdy, input bit st, input bit we,
                      input logic [4:0] a, input logic [7:0] d);
    RST = rst; EXE_RDY = rdy; START = st; WR_EN = we; WR_ADDR = a; WR_DATA = d;
    if (!rst && rdy && EXE_OP !== 4'hF) acc_log.push_back({EXE_OP, EXE_DATA});
    @(posedge CLK);
    model_edge();
    #1;
    chk("op",   32'(EXE_OP),   32'(e_op));
    chk("data", 32'(EXE_DATA), 32'(e_data));
    chk("enb",  32'(EXE_ENB),  32'(e_enb));
    chk("busy", 32'(BUSY),     32'(e_busy));
    chk("done", 32'(DONE),     32'(e_done));
    if (DONE === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 5'd0, 8'd0);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 5'd0, 8'd0);
    chk("rst_op", 32'(EXE_OP), 32'hF);
    chk("rst_enb", 32'(EXE_ENB), 32'h0);
    idle(1);
    chk("enb_after_rst", 32'(EXE_ENB), 32'h1);

    // Basic HELLO frame, ready pulsed every 10 cycles
    tick(0, 0, 0, 1, 5'd0, 8'h48);
    tick(0, 0, 0, 1, 5'd1, 8'h45);
    tick(0, 0, 0, 1, 5'd2, 8'h4C);
    tick(0, 0, 0, 1, 5'd3, 8'h4C);
    tick(0, 0, 0, 1, 5'd4, 8'h4F);
    acc_log.delete(); done_cnt = 0;
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < FLEN; k++) begin
      idle(9);
      tick(0, 1, 0, 0, 5'd0, 8'd0);
    end
    idle(2);
    exp_q = {12'h000, 12'h300, 12'h148, 12'h145, 12'h14C, 12'h14C, 12'h14F};
    for (int i = 0; i < 11; i++) exp_q.push_back(12'h120);
    exp_q.push_back(12'h340);
    for (int i = 0; i < 16; i++) exp_q.push_back(12'h120);
`ifdef LCD_MSG_HOLD_EN
    exp_q.push_back(12'h400);
`endif
    chk("hello_len", 32'(acc_log.size()), 32'(FLEN));
    for (int i = 0; i < FLEN && i < acc_log.size(); i++)
      chk($sformatf("hello[%0d]", i), 32'(acc_log[i]), 32'(exp_q[i]));
    chk("hello_done_cnt", 32'(done_cnt), 32'd1);
    chk("hello_op_idle", 32'(EXE_OP), 32'hF);

    // Continuous ready from START; ready in the DONE cycle must not advance
    acc_log.delete(); done_cnt = 0;
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < FLEN; k++) tick(0, 1, 0, 0, 5'd0, 8'd0);
    chk("cont_len", 32'(acc_log.size()), 32'(FLEN));
    chk("cont_op_end", 32'(EXE_OP), 32'hF);
    chk("cont_done", 32'(done_cnt), 32'd1);
    tick(0, 1, 0, 0, 5'd0, 8'd0);
    tick(0, 1, 0, 0, 5'd0, 8'd0);
    chk("cont_no_extra", 32'(acc_log.size()), 32'(FLEN));

    // Queued START after the 5th acceptance chains a second frame
    acc_log.delete(); done_cnt = 0;
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < 2 * FLEN + 1; k++) tick(0, 1, acc_log.size() == 5, 0, 5'd0, 8'd0);
    idle(2);
    chk("queued_len", 32'(acc_log.size()), 32'(2 * FLEN));
    chk("queued_done", 32'(done_cnt), 32'd2);
    if (acc_log.size() >= FLEN + 2) begin
      chk("queued_clr2", 32'(acc_log[FLEN]), 32'h000);
      chk("queued_addr2", 32'(acc_log[FLEN + 1]), 32'h300);
    end

    // Writes during a frame: one ahead of its fetch, one behind
    acc_log.delete();
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < FLEN; k++) begin
      tick(0, 0, 0, k == 6, 5'd20, 8'h41);
      tick(0, 0, 0, k == 6, 5'd2, 8'h42);
      tick(0, 1, 0, 0, 5'd0, 8'd0);
    end
    idle(2);
    chk("wr_len", 32'(acc_log.size()), 32'(FLEN));
    if (acc_log.size() == FLEN) begin
      chk("wr_late_pos2", 32'(acc_log[4]), 32'h14C);
      chk("wr_early_l2pos4", 32'(acc_log[COLS + 7]), 32'h141);
    end
    acc_log.delete();
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < FLEN; k++) tick(0, 1, 0, 0, 5'd0, 8'd0);
    idle(2);
    if (acc_log.size() == FLEN) chk("wr_next_pos2", 32'(acc_log[4]), 32'h142);
    else chk("wr_next_len", 32'(acc_log.size()), 32'(FLEN));

    // Reset mid-frame
    acc_log.delete(); done_cnt = 0;
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < 10; k++) tick(0, 1, 0, 0, 5'd0, 8'd0);
    tick(1, 1, 0, 0, 5'd0, 8'd0);
    chk("midrst_op", 32'(EXE_OP), 32'hF);
    chk("midrst_busy", 32'(BUSY), 32'h0);
    chk("midrst_enb", 32'(EXE_ENB), 32'h0);
    acc_log.delete();
    for (int k = 0; k < 5; k++) tick(0, 1, 0, 0, 5'd0, 8'd0);
    chk("midrst_no_adv", 32'(acc_log.size()), 32'd0);
    chk("midrst_no_done", 32'(done_cnt), 32'd0);
    tick(0, 0, 1, 0, 5'd0, 8'd0);
    for (int k = 0; k < FLEN; k++) tick(0, 1, 0, 0, 5'd0, 8'd0);
    idle(1);
    chk("midrst_len", 32'(acc_log.size()), 32'(FLEN));
    for (int i = 0; i < acc_log.size(); i++)
      if (acc_log[i][11:8] == 4'd1) chk($sformatf("midrst_fill[%0d]", i), 32'(acc_log[i][7:0]), 32'h20);

    // Randomized traffic
    for (int k = 0; k < 3000; k++)
      tick(($urandom % 700) == 0, ($urandom % 3) == 0, ($urandom % 45) == 0,
           ($urandom % 4) == 0, 5'($urandom), 8'($urandom));
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
